// File: rtl/tlb_maint_ctrl_if.sv
// Request/response bundle between the pipeline and the TLB maintenance controller.
interface tlb_maint_ctrl_if #(
  parameter int IDXW = 4
);
  logic            req_valid;
  logic [1:0]      req_op;
  logic [4:0]      req_inv_op;
  logic [9:0]      req_asid;
  logic [18:0]     req_vppn;
  logic [IDXW-1:0] req_idx;
  logic            req_ready;
  logic            done;
  logic            refetch;
  logic            err;

  modport master (
    output req_valid, req_op, req_inv_op, req_asid, req_vppn, req_idx,
    input  req_ready, done, refetch, err
  );

  modport slave (
    input  req_valid, req_op, req_inv_op, req_asid, req_vppn, req_idx,
    output req_ready, done, refetch, err
  );
endinterface

// File: rtl/tlb_maint_ctrl.sv
// TLB maintenance sequencer: TLBRD, TLBWR, TLBFILL and INVTLB over a TLBNUM-entry TLB.
// INVTLB walks every entry once and clears E on matching entries.
module tlb_maint_ctrl #(
  parameter int TLBNUM = 16,
  parameter int IDXW   = 4
) (
  input  logic                clk,
  input  logic                resetn,
  tlb_maint_ctrl_if.slave     bus,
  output logic [IDXW-1:0]     tlb_r_index,
  input  logic                r_e,
  input  logic                r_g,
  input  logic [5:0]          r_ps,
  input  logic [9:0]          r_asid,
  input  logic [18:0]         r_vppn,
  output logic                tlbrd_we,
  output logic                tlb_we,
  output logic [IDXW-1:0]     tlb_w_index,
  output logic                tlb_inv_we,
  output logic [IDXW-1:0]     tlb_inv_index
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_SCAN = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [1:0]      OP_RD   = 2'd0;
  localparam logic [1:0]      OP_WR   = 2'd1;
  localparam logic [1:0]      OP_FILL = 2'd2;
  localparam logic [1:0]      OP_INV  = 2'd3;
  localparam logic [IDXW-1:0] LAST    = IDXW'(TLBNUM - 1);
  localparam logic [IDXW-1:0] ONE     = IDXW'(1);

  state_t          state_r;
  state_t          state_s;
  logic [IDXW-1:0] cnt_r;
  logic [IDXW-1:0] rand_r;
  logic [IDXW-1:0] idx_r;
  logic [1:0]      op_r;
  logic [4:0]      inv_op_r;
  logic [9:0]      asid_r;
  logic [18:0]     vppn_r;
  logic            err_r;
  logic            accept_s;
  logic            inv_bad_s;
  logic            asid_eq_s;
  logic            va_eq_s;
  logic            match_s;

  assign accept_s  = bus.req_valid & (state_r == S_IDLE);
  assign inv_bad_s = (bus.req_op == OP_INV) & (bus.req_inv_op > 5'd6);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Free-running fill counter, scan counter and operands captured on acceptance
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rand_r   <= '0;
      cnt_r    <= '0;
      idx_r    <= '0;
      op_r     <= 2'd0;
      inv_op_r <= 5'd0;
      asid_r   <= 10'd0;
      vppn_r   <= 19'd0;
      err_r    <= 1'b0;
    end else begin
      rand_r <= (rand_r == LAST) ? '0 : rand_r + ONE;
      if (accept_s) begin
        cnt_r    <= '0;
        idx_r    <= bus.req_idx;
        op_r     <= bus.req_op;
        inv_op_r <= bus.req_inv_op;
        asid_r   <= bus.req_asid;
        vppn_r   <= bus.req_vppn;
        err_r    <= inv_bad_s;
      end else if (state_r == S_SCAN) begin
        cnt_r <= cnt_r + ONE;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          case (bus.req_op)
            OP_RD:   state_s = S_RD;
            OP_WR:   state_s = S_WR;
            OP_FILL: state_s = S_WR;
            default: state_s = inv_bad_s ? S_DONE : S_SCAN;
          endcase
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RD:    state_s = S_DONE;
      S_WR:    state_s = S_DONE;
      S_SCAN:  state_s = (cnt_r == LAST) ? S_DONE : S_SCAN;
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // INVTLB match on the entry currently presented by the read port
  always_comb begin
    asid_eq_s = (r_asid == asid_r);
    if (r_ps == 6'd21) begin
      va_eq_s = (r_vppn[18:10] == vppn_r[18:10]);
    end else begin
      va_eq_s = (r_vppn == vppn_r);
    end
    case (inv_op_r)
      5'd0, 5'd1: match_s = 1'b1;
      5'd2:       match_s = r_g;
      5'd3:       match_s = ~r_g;
      5'd4:       match_s = ~r_g & asid_eq_s;
      5'd5:       match_s = ~r_g & asid_eq_s & va_eq_s;
      5'd6:       match_s = (r_g | asid_eq_s) & va_eq_s;
      default:    match_s = 1'b0;
    endcase
  end

  // Output decode
  always_comb begin
    bus.req_ready = 1'b0;
    bus.done      = 1'b0;
    bus.refetch   = 1'b0;
    bus.err       = 1'b0;
    tlb_r_index   = '0;
    tlbrd_we      = 1'b0;
    tlb_we        = 1'b0;
    tlb_w_index   = '0;
    tlb_inv_we    = 1'b0;
    tlb_inv_index = '0;
    case (state_r)
      S_IDLE: bus.req_ready = 1'b1;
      S_RD: begin
        tlb_r_index = idx_r;
        tlbrd_we    = 1'b1;
      end
      S_WR: begin
        tlb_we      = 1'b1;
        tlb_w_index = (op_r == OP_FILL) ? rand_r : idx_r;
      end
      S_SCAN: begin
        tlb_r_index   = cnt_r;
        tlb_inv_index = cnt_r;
        tlb_inv_we    = r_e & match_s;
      end
      S_DONE: begin
        bus.done    = 1'b1;
        bus.err     = err_r;
        bus.refetch = ~err_r;
      end
      default: bus.req_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// Directed and randomized checks of tlb_maint_ctrl against a behavioural TLB model.
module tb_tlb_maint_ctrl;
  localparam int N = 16;
  localparam int W = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic [W-1:0]  tlb_r_index, tlb_w_index, tlb_inv_index;
  logic          tlbrd_we, tlb_we, tlb_inv_we;
  logic          r_e, r_g;
  logic [5:0]    r_ps;
  logic [9:0]    r_asid;
  logic [18:0]   r_vppn;

  logic          m_e    [N];
  logic          m_g    [N];
  logic [5:0]    m_ps   [N];
  logic [9:0]    m_asid [N];
  logic [18:0]   m_vppn [N];

  int tests = 0;
  int fails = 0;
  int edges;

  tlb_maint_ctrl_if #(.IDXW(W)) bus();

  tlb_maint_ctrl #(.TLBNUM(N), .IDXW(W)) dut (
    .clk(clk), .resetn(resetn), .bus(bus.slave),
    .tlb_r_index(tlb_r_index), .r_e(r_e), .r_g(r_g), .r_ps(r_ps),
    .r_asid(r_asid), .r_vppn(r_vppn),
    .tlbrd_we(tlbrd_we), .tlb_we(tlb_we), .tlb_w_index(tlb_w_index),
    .tlb_inv_we(tlb_inv_we), .tlb_inv_index(tlb_inv_index)
  );

  always #5 clk = ~clk;

  // Clock edges seen since reset release; the fill counter must equal this modulo N
  always @(posedge clk or negedge resetn) begin
    if (!resetn) edges <= 0;
    else         edges <= edges + 1;
  end

  assign r_e    = m_e[tlb_r_index];
  assign r_g    = m_g[tlb_r_index];
  assign r_ps   = m_ps[tlb_r_index];
  assign r_asid = m_asid[tlb_r_index];
  assign r_vppn = m_vppn[tlb_r_index];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " outs"}, {tlbrd_we, tlb_we, tlb_inv_we, bus.done, bus.refetch, bus.err,
                           tlb_r_index, tlb_w_index, tlb_inv_index}, 32'd0);
    check({tag, " ready"}, bus.req_ready, 32'd1);
  endtask

  task automatic send(input logic [1:0] op, input logic [4:0] iop, input logic [9:0] a,
                      input logic [18:0] v, input logic [W-1:0] idx);
    bus.req_op = op; bus.req_inv_op = iop; bus.req_asid = a;
    bus.req_vppn = v; bus.req_idx = idx; bus.req_valid = 1'b1;
    check("accept ready", bus.req_ready, 32'd1);
    step();
    bus.req_valid = 1'b0;
  endtask

  function automatic logic model_hit(input int i, input logic [4:0] iop,
                                     input logic [9:0] a, input logic [18:0] v);
    logic aeq, veq, hit;
    aeq = (m_asid[i] == a);
    veq = (m_ps[i] == 6'd21) ? (m_vppn[i][18:10] == v[18:10]) : (m_vppn[i] == v);
    case (iop)
      5'd0, 5'd1: hit = 1'b1;
      5'd2:       hit = m_g[i];
      5'd3:       hit = !m_g[i];
      5'd4:       hit = !m_g[i] && aeq;
      5'd5:       hit = !m_g[i] && aeq && veq;
      5'd6:       hit = (m_g[i] || aeq) && veq;
      default:    hit = 1'b0;
    endcase
    return m_e[i] && hit;
  endfunction

  task automatic run_inv(input string tag, input logic [4:0] iop, input logic [9:0] a,
                         input logic [18:0] v, output logic [N-1:0] got);
    logic [N-1:0] want;
    for (int i = 0; i < N; i++) want[i] = model_hit(i, iop, a, v);
    got = '0;
    send(2'd3, iop, a, v, W'($urandom_range(0, N - 1)));
    for (int k = 0; k < N; k++) begin
      check({tag, " scan index"}, tlb_r_index, k);
      check({tag, " scan quiet"}, {tlbrd_we, tlb_we, bus.done, bus.req_ready}, 32'd0);
      if (tlb_inv_we) begin
        got[tlb_inv_index] = 1'b1;
        m_e[tlb_inv_index] = 1'b0;
      end
      step();
    end
    check({tag, " inv mask"}, got, want);
    check({tag, " done/refetch/err"}, {bus.done, bus.refetch, bus.err, tlb_inv_we}, 32'b1100);
    step();
    check_quiet({tag, " after"});
  endtask

  task automatic clear_tlb();
    for (int i = 0; i < N; i++) begin
      m_e[i] = 1'b0; m_g[i] = 1'b0; m_ps[i] = 6'd12; m_asid[i] = 10'd0; m_vppn[i] = 19'd0;
    end
  endtask

  logic [N-1:0]  got;
  logic [18:0]   vpool [3];
  logic [9:0]    apool [3];
  logic [1:0]    rop;
  logic [W-1:0]  ridx;
  logic [N-1:0]  alive;

  initial begin
    resetn = 1'b0;
    bus.req_valid = 1'b0; bus.req_op = 2'd0; bus.req_inv_op = 5'd0;
    bus.req_asid = 10'd0; bus.req_vppn = 19'd0; bus.req_idx = '0;
    clear_tlb();
    #12;
    check_quiet("reset");
    resetn = 1'b1;
    step();
    check_quiet("post reset");

    // TLBRD idx 5, with a stray request held during RD that must be ignored
    send(2'd0, 5'd0, 10'd0, 19'd0, 4'd5);
    check("rd strobe", {tlbrd_we, tlb_r_index, tlb_we, tlb_inv_we}, {26'd0, 1'b1, 4'd5, 2'b00});
    bus.req_op = 2'd3; bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    check("rd done", {bus.done, bus.refetch, bus.err, tlbrd_we}, 32'b1100);
    step();
    check_quiet("rd idle");

    // TLBFILL while the fill counter reads 8
    for (int b = 0; b < N && (edges % N) != 8; b++) step();
    send(2'd2, 5'd0, 10'd0, 19'd0, 4'd10);
    check("fill index", {tlb_we, tlb_w_index, tlbrd_we}, {27'd0, 1'b1, 4'd9, 1'b0});
    step();
    check("fill done", {bus.done, bus.refetch, bus.err}, 32'b110);
    step();
    send(2'd1, 5'd0, 10'd0, 19'd0, 4'd3);
    check("wr index", {tlb_we, tlb_w_index}, {27'd0, 1'b1, 4'd3});
    step();
    check("wr done", {bus.done, bus.refetch, bus.err}, 32'b110);
    step();

    // Randomized RD/WR/FILL
    for (int t = 0; t < 12; t++) begin
      rop  = 2'($urandom_range(0, 2));
      ridx = W'($urandom_range(0, N - 1));
      send(rop, 5'd0, 10'd0, 19'd0, ridx);
      if (rop == 2'd0)
        check("rnd rd", {tlbrd_we, tlb_we, tlb_r_index}, {26'd0, 2'b10, ridx});
      else
        check("rnd wr", {tlbrd_we, tlb_we, tlb_w_index},
              {26'd0, 2'b01, (rop == 2'd2) ? W'(edges % N) : ridx});
      step();
      check("rnd done", {bus.done, bus.refetch, bus.err}, 32'b110);
      step();
    end

    // Invalid INVTLB op
    send(2'd3, 5'd9, 10'd0, 19'd0, 4'd0);
    check("bad op", {bus.done, bus.err, bus.refetch, tlbrd_we, tlb_we, tlb_inv_we}, 32'b110000);
    step();
    check_quiet("bad op idle");

    // inv_op 5: only entry 2 qualifies, global entry 7 is kept
    clear_tlb();
    m_e[2] = 1'b1; m_asid[2] = 10'h12; m_vppn[2] = 19'h1234A;
    m_e[7] = 1'b1; m_g[7] = 1'b1; m_asid[7] = 10'h12; m_vppn[7] = 19'h1234A;
    run_inv("inv5", 5'd5, 10'h12, 19'h1234A, got);
    check("inv5 entry2", got, 32'h0004);

    // inv_op 6 on a 2M page differing only in the low VA bits
    clear_tlb();
    m_e[9] = 1'b1; m_g[9] = 1'b1; m_ps[9] = 6'd21; m_vppn[9] = 19'h5A3C1;
    m_e[4] = 1'b1; m_g[4] = 1'b1; m_ps[4] = 6'd12; m_vppn[4] = 19'h5A3C1;
    run_inv("inv6", 5'd6, 10'h3FF, 19'h5A3C1 ^ 19'h002AA, got);
    check("inv6 entry9", got, 32'h0200);

    // Randomized INVTLB against the model
    apool[0] = 10'h12; apool[1] = 10'h34; apool[2] = 10'(($urandom));
    vpool[0] = 19'h0ABCD; vpool[1] = 19'h7F001; vpool[2] = 19'h0ABCD ^ 19'h00155;
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < N; i++) begin
        m_e[i]    = 1'($urandom_range(0, 1));
        m_g[i]    = 1'($urandom_range(0, 1));
        m_ps[i]   = ($urandom_range(0, 1) != 0) ? 6'd21 : 6'd12;
        m_asid[i] = apool[$urandom_range(0, 2)];
        m_vppn[i] = vpool[$urandom_range(0, 2)];
      end
      run_inv("rnd inv", 5'($urandom_range(0, 6)), apool[$urandom_range(0, 2)],
              vpool[$urandom_range(0, 2)], got);
    end

    // Reset during the scan at cnt 4
    for (int i = 0; i < N; i++) m_e[i] = 1'b1;
    send(2'd3, 5'd0, 10'd0, 19'd0, 4'd0);
    for (int k = 0; k < 4; k++) begin
      if (tlb_inv_we) m_e[tlb_inv_index] = 1'b0;
      step();
    end
    check("pre-reset cnt", {tlb_r_index, tlb_inv_we}, {27'd0, 4'd4, 1'b1});
    resetn = 1'b0;
    #1;
    check_quiet("mid-scan reset");
    @(negedge clk);
    resetn = 1'b1;
    send(2'd0, 5'd0, 10'd0, 19'd0, 4'd6);
    check("post-reset rd", {tlbrd_we, tlb_r_index, bus.done, tlb_inv_we}, {27'd0, 1'b1, 4'd6, 2'b00});
    step();
    check("post-reset done", {bus.done, bus.refetch, bus.err}, 32'b110);
    for (int i = 0; i < N; i++) alive[i] = m_e[i];
    check("partial scan", alive, 32'hFFF0);
    step();
    check_quiet("end");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tlb_maint_ctrl.md
TLB_MAINT_CTRL -- requirements
Module: tlb_maint_ctrl

Interface
REQ-001 SHALL have parameter TLBNUM, default 16, number of TLB entries; a power of two.
REQ-002 SHALL have parameter IDXW, default 4, index width, equal to log2(TLBNUM).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1 bit: a TLB maintenance op is offered.
REQ-006 SHALL have port req_op, input, 2 bits: 0=TLBRD, 1=TLBWR, 2=TLBFILL, 3=INVTLB.
REQ-007 SHALL have ports req_inv_op (5 bits), req_asid (10), req_vppn (19) and req_idx (IDXW), all inputs: INVTLB operands and the TLBIDX index.
REQ-008 SHALL have port req_ready, output, 1 bit: the request is accepted when req_valid & req_ready.
REQ-009 SHALL have ports done, refetch and err, outputs, 1 bit each: completion pulse, pipeline refetch request, and invalid-op flag.
REQ-010 SHALL have ports tlb_r_index (IDXW, output) and r_e, r_g, r_ps (6), r_asid (10), r_vppn (19), all inputs: the TLB read port with same-cycle read data.
REQ-011 SHALL have ports tlbrd_we, tlb_we and tlb_w_index (IDXW), outputs: CSR load strobe, TLB entry write strobe and write index.
REQ-012 SHALL have ports tlb_inv_we (1) and tlb_inv_index (IDXW), outputs: clear the E bit of the indexed entry.

Function
REQ-013 SHALL implement the FSM states IDLE, RD, WR, SCAN and DONE; req_ready=1 only in IDLE.
REQ-014 SHALL latch op, operands and idx on acceptance; req_valid outside IDLE is ignored and causes no state change.
REQ-015 IDLE SHALL go to RD (TLBRD), WR (TLBWR/TLBFILL), or SCAN (INVTLB with inv_op<=6), with the scan counter cleared.
REQ-016 IDLE with INVTLB and inv_op>6 SHALL go straight to DONE with err set, and SHALL issue no TLB strobes.
REQ-017 RD SHALL last one cycle, with tlb_r_index=idx and tlbrd_we=1, then go to DONE.
REQ-018 WR SHALL last one cycle with tlb_we=1, then go to DONE.
REQ-019 In WR, tlb_w_index SHALL be idx for TLBWR, or the random counter value sampled in that WR cycle for TLBFILL.
REQ-020 The random counter SHALL be free-running over IDXW bits, +1 every cycle, wrapping from TLBNUM-1 to 0, in every state.
REQ-021 SCAN SHALL drive tlb_r_index=cnt and tlb_inv_index=cnt, and SHALL increment cnt each cycle.
REQ-022 SCAN SHALL go to DONE in the cycle cnt=TLBNUM-1, after evaluating that entry, for exactly TLBNUM scan cycles.
REQ-023 In SCAN, tlb_inv_we SHALL equal r_e & match, using the same-cycle read data.
REQ-024 The INVTLB match SHALL be: inv_op 0/1: 1; inv_op 2: G; inv_op 3: !G; inv_op 4: !G & asid_eq; inv_op 5: !G & asid_eq & va_eq; inv_op 6: (G | asid_eq) & va_eq.
REQ-025 asid_eq SHALL be r_asid==req_asid.
REQ-026 va_eq SHALL compare vppn[18:10] when r_ps==21 and vppn[18:0] otherwise.
REQ-027 DONE SHALL last one cycle with done=1 and refetch=!err, then return to IDLE; err is valid only while done=1.
REQ-028 Outside their states, tlbrd_we, tlb_we, tlb_inv_we, done, refetch and err SHALL be 0, and all index outputs SHALL be 0.
REQ-029 Latency from the acceptance edge SHALL be: RD/WR strobe in the next cycle and done one cycle later; SCAN strobes in cycles +1..+TLBNUM and done at +TLBNUM+1; invalid op gives done at +1.
REQ-030 At most one strobe among tlbrd_we, tlb_we and tlb_inv_we SHALL be high in any cycle.

Reset
REQ-031 resetn=0 SHALL force IDLE, cnt=0, the random counter=0, all outputs 0 except req_ready=1, and cleared latched operands, immediately and independent of clk.
REQ-032 Reset asserted mid-SCAN SHALL abandon the scan with no further tlb_inv_we and no done pulse; entries already cleared stay cleared.

Verification
REQ-033 TLBRD with idx=5 -> next cycle tlb_r_index=5 and tlbrd_we=1; following cycle done=1, refetch=1, err=0.
REQ-034 TLBFILL accepted while the random counter reads 8 -> WR cycle shows tlb_w_index=9 with tlb_we=1; TLBWR with idx=3 -> tlb_w_index=3.
REQ-035 INVTLB inv_op=5, asid=0x12, with entries 2 (G=0, asid 0x12, VA match) and 7 (G=1) valid -> tlb_inv_we only at cnt=2; done 17 cycles after accept.
REQ-036 INVTLB inv_op=6 on an entry with ps=21 and a VA differing only in vppn[9:0] -> the entry is invalidated.
REQ-037 INVTLB inv_op=9 -> done=1, err=1, refetch=0 one cycle after accept, no strobes.
REQ-038 Reset pulse at scan cnt=4 -> IDLE, req_ready=1, no done pulse; a new request is accepted in the cycle after reset deasserts.
